// File: rtl/tbcm_stream_mux.sv
// Registered N:1 valid/ready stream multiplexer with packet locking.
// Source chosen by external select (one-hot or binary) or round-robin arbitration.
module tbcm_stream_mux #(
    parameter int  WIDTH       = 2,
    parameter type DATA_TYPE   = logic [WIDTH-1:0],
    parameter int  ENTRIES     = 2,
    parameter int  ARBITRATION = 0,
    parameter int  ONE_HOT     = 1,
    localparam int INDEX_WIDTH  = $clog2(ENTRIES),
    localparam int SELECT_WIDTH = ONE_HOT ? ENTRIES : INDEX_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SELECT_WIDTH-1:0] i_select,
    input  logic [ENTRIES-1:0]      i_valid,
    output logic [ENTRIES-1:0]      o_ready,
    input  DATA_TYPE                i_data [ENTRIES],
    input  logic [ENTRIES-1:0]      i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output DATA_TYPE                o_data,
    output logic                    o_last,
    output logic [ENTRIES-1:0]      o_grant
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [INDEX_WIDTH-1:0] lock_idx_reg, lock_idx_next;
    logic [INDEX_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ENTRIES-1:0]     grant_reg, grant_next;
    logic                   valid_reg, valid_next;
    DATA_TYPE               data_reg, data_next;
    logic                   last_reg, last_next;

    logic                   idle_found;
    logic [INDEX_WIDTH-1:0] idle_idx;
    logic                   cand_found;
    logic [INDEX_WIDTH-1:0] cand_idx;
    logic                   load;
    logic                   xfer;
    DATA_TYPE               cand_data;
    logic                   cand_last;

    generate
        if (ARBITRATION != 0) begin : g_round_robin
            // rr_idx[gi] is the channel gi positions after the pointer, wrapped at ENTRIES
            logic [ENTRIES-1:0][INDEX_WIDTH-1:0] rr_idx;

            for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rot
                logic [INDEX_WIDTH:0] sum;
                assign sum = {1'b0, ptr_reg} + (INDEX_WIDTH+1)'(gi);
                assign rr_idx[gi] = (sum >= (INDEX_WIDTH+1)'(ENTRIES))
                                  ? INDEX_WIDTH'(sum - (INDEX_WIDTH+1)'(ENTRIES))
                                  : INDEX_WIDTH'(sum);
            end

            // Scan farthest-first so the nearest valid channel to the pointer wins
            always_comb begin
                idle_found = 1'b0;
                idle_idx   = '0;
                for (int off = ENTRIES - 1; off >= 0; off--) begin
                    if (i_valid[rr_idx[off]]) begin
                        idle_found = 1'b1;
                        idle_idx   = rr_idx[off];
                    end
                end
            end
        end else if (ONE_HOT != 0) begin : g_select_onehot
            always_comb begin
                idle_found = 1'b0;
                idle_idx   = '0;
                for (int k = ENTRIES - 1; k >= 0; k--) begin
                    if (i_select[k]) begin
                        idle_found = 1'b1;
                        idle_idx   = INDEX_WIDTH'(k);
                    end
                end
            end
        end else begin : g_select_binary
            assign idle_found = ({1'b0, i_select} < (SELECT_WIDTH+1)'(ENTRIES));
            assign idle_idx   = INDEX_WIDTH'(i_select);
        end
    endgenerate

    always_comb begin
        cand_found = idle_found;
        cand_idx   = idle_idx;
        if (state_reg == LOCKED) begin
            cand_found = 1'b1;
            cand_idx   = lock_idx_reg;
        end
    end

    assign load = !valid_reg || i_ready;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ready
            assign o_ready[gi] = !i_rst && load && cand_found
                               && (cand_idx == INDEX_WIDTH'(gi));
        end
    endgenerate

    assign xfer      = |(o_ready & i_valid);
    assign cand_data = i_data[cand_idx];
    assign cand_last = i_last[cand_idx];

    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        ptr_next      = ptr_reg;
        grant_next    = grant_reg;
        valid_next    = valid_reg;
        data_next     = data_reg;
        last_next     = last_reg;
        if (xfer) begin
            valid_next = 1'b1;
            data_next  = cand_data;
            last_next  = cand_last;
            if (cand_last) begin
                state_next = IDLE;
                grant_next = '0;
                if (ARBITRATION != 0) begin
                    ptr_next = (cand_idx == INDEX_WIDTH'(ENTRIES - 1))
                             ? '0 : cand_idx + INDEX_WIDTH'(1);
                end
            end else begin
                state_next    = LOCKED;
                lock_idx_next = cand_idx;
                grant_next    = ENTRIES'(1) << cand_idx;
            end
        end else if (load) begin
            // Register drained with nothing to replace it
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            lock_idx_reg <= '0;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            last_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
            ptr_reg      <= ptr_next;
            grant_reg    <= grant_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            last_reg     <= last_next;
        end
    end

    assign o_valid = valid_reg;
    assign o_data  = data_reg;
    assign o_last  = last_reg;
    assign o_grant = grant_reg;

endmodule

// File: tb/tb_tbcm_stream_mux.sv
// Bench for tbcm_stream_mux: three configurations (one-hot select, binary select,
// round-robin over 3 channels) driven together and compared to a reference model.
module tb_tbcm_stream_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus per configuration d: 0 = one-hot/4ch, 1 = binary/4ch, 2 = round-robin/3ch
    logic [3:0] t_valid [3];
    logic [7:0] t_data  [3][4];
    logic [3:0] t_last  [3];
    logic       t_ready [3];
    logic [3:0] t_sel   [3];

    logic [7:0] a_idata [4];
    logic [7:0] b_idata [4];
    logic [7:0] c_idata [3];
    logic [3:0] a_ready, b_ready, a_grant, b_grant;
    logic [2:0] c_ready, c_grant;
    logic       a_valid, b_valid, c_valid, a_last, b_last, c_last;
    logic [7:0] a_odata, b_odata, c_odata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_data
        assign a_idata[gi] = t_data[0][gi];
        assign b_idata[gi] = t_data[1][gi];
        if (gi < 3) begin : g_c
            assign c_idata[gi] = t_data[2][gi];
        end
    end

    tbcm_stream_mux #(.WIDTH(8), .ENTRIES(4), .ARBITRATION(0), .ONE_HOT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_select(t_sel[0]), .i_valid(t_valid[0]),
        .o_ready(a_ready), .i_data(a_idata), .i_last(t_last[0]), .o_valid(a_valid),
        .i_ready(t_ready[0]), .o_data(a_odata), .o_last(a_last), .o_grant(a_grant));

    tbcm_stream_mux #(.WIDTH(8), .ENTRIES(4), .ARBITRATION(0), .ONE_HOT(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_select(t_sel[1][1:0]), .i_valid(t_valid[1]),
        .o_ready(b_ready), .i_data(b_idata), .i_last(t_last[1]), .o_valid(b_valid),
        .i_ready(t_ready[1]), .o_data(b_odata), .o_last(b_last), .o_grant(b_grant));

    tbcm_stream_mux #(.WIDTH(8), .ENTRIES(3), .ARBITRATION(1), .ONE_HOT(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_select(t_sel[2][1:0]), .i_valid(t_valid[2][2:0]),
        .o_ready(c_ready), .i_data(c_idata), .i_last(t_last[2][2:0]), .o_valid(c_valid),
        .i_ready(t_ready[2]), .o_data(c_odata), .o_last(c_last), .o_grant(c_grant));

    // Reference model
    int   ents [3] = '{4, 4, 3};
    bit   arbm [3] = '{1'b0, 1'b0, 1'b1};
    bit   ohm  [3] = '{1'b1, 1'b0, 1'b0};
    bit         m_valid  [3];
    logic [7:0] m_data   [3];
    bit         m_last   [3];
    logic [3:0] m_grant  [3];
    bit         m_locked [3];
    int         m_ch     [3];
    int         m_ptr    [3];
    logic [3:0] obs_ready [3];

    int errors = 0;
    int checks = 0;

    function automatic logic [3:0] dut_ready(int d);
        if (d == 0) return a_ready;
        if (d == 1) return b_ready;
        return {1'b0, c_ready};
    endfunction
    function automatic logic [3:0] dut_grant(int d);
        if (d == 0) return a_grant;
        if (d == 1) return b_grant;
        return {1'b0, c_grant};
    endfunction
    function automatic logic dut_valid(int d);
        if (d == 0) return a_valid;
        if (d == 1) return b_valid;
        return c_valid;
    endfunction
    function automatic logic [7:0] dut_data(int d);
        if (d == 0) return a_odata;
        if (d == 1) return b_odata;
        return c_odata;
    endfunction
    function automatic logic dut_last(int d);
        if (d == 0) return a_last;
        if (d == 1) return b_last;
        return c_last;
    endfunction

    // Channel the mux should offer ready to this cycle, or -1 for none
    function automatic int pick(int d);
        if (m_locked[d]) return m_ch[d];
        if (arbm[d]) begin
            for (int s = 0; s < ents[d]; s++) begin
                int k;
                k = (m_ptr[d] + s) % ents[d];
                if (t_valid[d][k]) return k;
            end
            return -1;
        end
        if (ohm[d]) begin
            for (int k = 0; k < ents[d]; k++)
                if (t_sel[d][k]) return k;
            return -1;
        end
        if (int'(t_sel[d][1:0]) < ents[d]) return int'(t_sel[d][1:0]);
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_data[d] = '0; m_last[d] = 0; m_grant[d] = '0;
            m_locked[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
        end
    endtask

    task automatic model_advance(int d);
        int  c;
        bit  ld;
        c  = pick(d);
        ld = !m_valid[d] || t_ready[d];
        if (c >= 0 && ld && t_valid[d][c]) begin
            m_valid[d] = 1;
            m_data[d]  = t_data[d][c];
            m_last[d]  = t_last[d][c];
            if (t_last[d][c]) begin
                m_locked[d] = 0;
                m_grant[d]  = '0;
                if (arbm[d]) m_ptr[d] = (c + 1) % ents[d];
            end else begin
                m_locked[d] = 1;
                m_ch[d]     = c;
                m_grant[d]  = 4'(1 << c);
            end
        end else if (ld) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic chk(string tag, int d, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, d, obs, exp, $time);
            $error("%s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic check_outs(string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_valid"}, d, {7'b0, dut_valid(d)}, {7'b0, m_valid[d]});
            chk({tag, "_data"},  d, dut_data(d), m_data[d]);
            chk({tag, "_last"},  d, {7'b0, dut_last(d)}, {7'b0, m_last[d]});
            chk({tag, "_grant"}, d, {4'b0, dut_grant(d)}, {4'b0, m_grant[d]});
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge
    task automatic step();
        #1;
        if (rst) begin
            model_reset();
            check_outs("rst_async");
        end
        for (int d = 0; d < 3; d++) begin
            int         c;
            logic [3:0] exp;
            c   = pick(d);
            exp = (!rst && (!m_valid[d] || t_ready[d]) && c >= 0) ? 4'(1 << c) : 4'b0;
            obs_ready[d] = dut_ready(d);
            chk("ready", d, {4'b0, obs_ready[d]}, {4'b0, exp});
        end
        if (!rst)
            for (int d = 0; d < 3; d++) model_advance(d);
        @(negedge clk);
        check_outs("out");
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 3; d++) begin
            t_valid[d] = '0; t_last[d] = '0; t_ready[d] = 1'b1; t_sel[d] = '0;
            for (int k = 0; k < 4; k++) t_data[d][k] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single-beat packet through one-hot select
        clear_inputs();
        t_sel[0] = 4'b0100; t_valid[0][2] = 1'b1; t_data[0][2] = 8'hA5; t_last[0][2] = 1'b1;
        step();
        chk("tp1_ready", 0, {4'b0, obs_ready[0]}, 8'h04);
        chk("tp1_data",  0, a_odata, 8'hA5);
        chk("tp1_valid", 0, {7'b0, a_valid}, 8'h01);
        chk("tp1_grant", 0, {4'b0, a_grant}, 8'h00);

        // Lock: 3 beats on ch1 while select moves to ch3 after the first beat
        clear_inputs();
        t_sel[1] = 4'd1; t_valid[1] = 4'b1010; t_last[1] = 4'b1000;
        t_data[1][1] = 8'h11; t_data[1][3] = 8'h33;
        step();
        t_sel[1] = 4'd3; t_data[1][1] = 8'h12;
        step();
        chk("lock_grant", 1, {4'b0, b_grant}, 8'h02);
        chk("lock_data",  1, b_odata, 8'h12);
        t_data[1][1] = 8'h13; t_last[1][1] = 1'b1;
        step();
        chk("lock_last_data", 1, b_odata, 8'h13);
        step();
        chk("switch_ready", 1, {4'b0, obs_ready[1]}, 8'h08);
        chk("switch_data",  1, b_odata, 8'h33);
        chk("switch_valid", 1, {7'b0, b_valid}, 8'h01);

        // Backpressure: output holds for 3 stalled cycles, then drains and reloads
        clear_inputs();
        t_sel[0] = 4'b0001; t_valid[0][0] = 1'b1; t_data[0][0] = 8'h40;
        step();
        t_ready[0] = 1'b0; t_data[0][0] = 8'h41;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", 0, a_odata, 8'h40);
            chk("bp_ready", 0, {4'b0, obs_ready[0]}, 8'h00);
        end
        t_ready[0] = 1'b1;
        step();
        chk("bp_drain", 0, a_odata, 8'h41);
        t_last[0][0] = 1'b1; t_data[0][0] = 8'h42;
        step();

        // Round-robin over three always-valid channels, then wrap at 3
        do_reset();
        clear_inputs();
        t_valid[2] = 4'b0111; t_last[2] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_order", 2, {4'b0, obs_ready[2]}, {4'b0, rr_order[i]});
        end
        t_valid[2] = 4'b0101;
        step();
        chk("rr_wrap_hi", 2, {4'b0, obs_ready[2]}, 8'h04);
        step();
        chk("rr_wrap_lo", 2, {4'b0, obs_ready[2]}, 8'h01);
        do_reset();
        t_valid[2] = 4'b0100;
        step();
        chk("rr_only2", 2, {4'b0, obs_ready[2]}, 8'h04);

        // Reset in the middle of a 4-beat packet, then a packet on another channel
        clear_inputs();
        t_sel[0] = 4'b0010; t_valid[0][1] = 1'b1; t_data[0][1] = 8'h51;
        step();
        t_data[0][1] = 8'h52;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 0, {7'b0, a_valid}, 8'h00);
        chk("mid_rst_grant", 0, {4'b0, a_grant}, 8'h00);
        step();
        rst = 1'b0;
        clear_inputs();
        t_sel[0] = 4'b0100; t_valid[0][2] = 1'b1; t_data[0][2] = 8'h77; t_last[0][2] = 1'b1;
        step();
        chk("post_rst_ready", 0, {4'b0, obs_ready[0]}, 8'h04);
        chk("post_rst_data",  0, a_odata, 8'h77);

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 3; d++) begin
                t_valid[d] = 4'($urandom);
                t_sel[d]   = 4'($urandom);
                t_ready[d] = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 4; k++) begin
                    t_data[d][k] = 8'($urandom);
                    t_last[d][k] = ($urandom_range(0, 2) == 0);
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tbcm_stream_mux.md
Name: tbcm_stream_mux

Overview:
- Registered N:1 valid/ready stream multiplexer; successor to the combinational select mux.
- Source selection is either an external select (one-hot or binary) or internal round-robin arbitration.
- Once a packet starts, the grant is held until its last beat has been transferred.
- A one-entry output register sits between the chosen source and the single downstream port, and sustains full throughput.

Parameters:
- WIDTH, 2: payload bit width when DATA_TYPE is left at its default.
- DATA_TYPE, logic [WIDTH-1:0]: payload type.
- ENTRIES, 2: number of input channels, minimum 2.
- ARBITRATION, 0: 0 = external select via i_select; 1 = round-robin, i_select ignored.
- ONE_HOT, 1: in external mode, i_select is one-hot (ENTRIES bits) when 1, binary index when 0.
- INDEX_WIDTH (localparam), $clog2(ENTRIES): index width.
- SELECT_WIDTH (localparam): ONE_HOT ? ENTRIES : INDEX_WIDTH.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_select, input, SELECT_WIDTH: source select; sampled only in IDLE and only when ARBITRATION=0.
- i_valid, input, [ENTRIES]: per-channel valid.
- o_ready, output, [ENTRIES]: per-channel ready.
- i_data, input, DATA_TYPE[ENTRIES]: per-channel payload.
- i_last, input, [ENTRIES]: per-channel end-of-packet flag.
- o_valid, output, 1: downstream valid.
- i_ready, input, 1: downstream ready.
- o_data, output, DATA_TYPE: downstream payload.
- o_last, output, 1: downstream end-of-packet flag.
- o_grant, output, ENTRIES: one-hot of the locked channel; all zero in IDLE.

Behaviour:
- Reset (asynchronous assert; release is synchronised by the surrounding system):
  - o_valid=0, o_data='0, o_last=0, o_grant='0, state=IDLE, round-robin pointer=0.
  - o_ready is all zero while i_rst=1.
- Load enable: load = !o_valid || i_ready. The output register accepts a beat whenever it is empty or being drained, giving 1 beat/cycle.
- Candidate selection, IDLE state:
  - ARBITRATION=0, ONE_HOT=1: candidate = lowest set bit of i_select. An all-zero select means no candidate.
  - ARBITRATION=0, ONE_HOT=0: candidate = i_select. An index >= ENTRIES means no candidate.
  - ARBITRATION=1: candidate = first k with i_valid[k]=1, searching from pointer upward with wrap to 0. No valid channel means no candidate.
- Candidate selection, LOCKED state: candidate = the locked channel. i_select and the other channels' valids are ignored.
- Ready: o_ready[k] = load && (k == candidate). Exactly one bit or none is set. In round-robin IDLE, o_ready is combinationally dependent on i_valid; this is permitted.
- Transfer: a transfer occurs when i_valid[cand] && o_ready[cand]. On a transfer:
  - o_data <= i_data[cand], o_last <= i_last[cand], o_valid <= 1.
- Clearing o_valid: when load=1 with no transfer, o_valid <= 0. When load=0, the output register holds and stays stable under backpressure.
- State transitions:
  - IDLE -> LOCKED: on a transfer with i_last=0; o_grant <= onehot(cand).
  - IDLE -> IDLE: on a transfer with i_last=1 (single-beat packet); o_grant stays 0.
  - LOCKED -> IDLE: on a transfer with i_last=1; o_grant <= 0.
  - No transfer: state holds. LOCKED persists indefinitely if the source stalls.
- Pointer: on every transfer with i_last=1, pointer <= (cand+1) mod ENTRIES. Otherwise the pointer holds. Applies in round-robin mode only.
- Latency: input beat to o_valid is 1 cycle. There is no bubble between back-to-back packets, including a switch of channel.
- Reset mid-packet: all state clears immediately, the partial packet is dropped downstream, and the lock is released.
- Width rules: o_data is zero-extended only through DATA_TYPE; no arithmetic. The pointer wraps at ENTRIES, which may be a non-power-of-two.

Test Plan:
- Single-beat: ENTRIES=4, ARB=0, ONE_HOT=1, select=4'b0100, i_valid[2]=1, i_data[2]=8'hA5, last=1, i_ready=1 -> o_ready=4'b0100 that cycle; next cycle o_valid=1, o_data=A5, o_last=1, o_grant=0.
- Lock: 3-beat packet on ch1 (binary select=1), select changed to 3 after beat 1 -> all 3 beats come from ch1, o_grant=4'b0010 until last transferred, then ch3 is granted with no idle cycle.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 -> o_data/o_last stable, o_ready=0; i_ready=1 -> stalled beat drains and the next beat loads the same cycle.
- Round-robin: ARB=1, ENTRIES=3, all valid, single-beat packets -> grant order 0,1,2,0,1; with only ch2 valid after reset -> ch2 granted first.
- Non-power-of-two wrap: ENTRIES=3, pointer=2, ch0 and ch2 valid -> ch2 granted, pointer becomes 0.
- Reset mid-packet: assert i_rst after beat 2 of 4 -> o_valid=0, o_grant=0 in the same cycle (async); after release a new packet on another channel is granted.
